// File: rtl/smi_mem_lib_write_test_sequencer64_if.sv
// Per-burst test parameter and done port between the campaign sequencer
// (master) and the 64-bit SMI memory-library write-burst test source (slave).
interface smi_mem_lib_write_test_sequencer64_if;
   logic        testParamsValid;
   logic [63:0] testParamBurstAddr;
   logic [31:0] testParamBurstLen;
   logic [7:0]  testParamBurstOpts;
   logic [63:0] testParamDataInit;
   logic [63:0] testParamDataIncr;
   logic        testParamsStop;
   logic        testDoneValid;
   logic        testDoneStatusOk;
   logic        testDoneStop;

   modport master (
      output testParamsValid,
      output testParamBurstAddr,
      output testParamBurstLen,
      output testParamBurstOpts,
      output testParamDataInit,
      output testParamDataIncr,
      input  testParamsStop,
      input  testDoneValid,
      input  testDoneStatusOk,
      output testDoneStop
   );

   modport slave (
      input  testParamsValid,
      input  testParamBurstAddr,
      input  testParamBurstLen,
      input  testParamBurstOpts,
      input  testParamDataInit,
      input  testParamDataIncr,
      output testParamsStop,
      output testDoneValid,
      output testDoneStatusOk,
      input  testDoneStop
   );
endinterface

// File: rtl/smi_mem_lib_write_test_sequencer64.sv
// Campaign sequencer: turns one campaign descriptor into a series of write-burst
// tests at stepped addresses with continuous data, then reports a pass/fail summary.
module smi_mem_lib_write_test_sequencer64 (
   input  logic        clk,
   input  logic        srst,

   input  logic        campParamsValid,
   input  logic [63:0] campBaseAddr,
   input  logic [63:0] campAddrStride,
   input  logic [31:0] campBurstLen,
   input  logic [15:0] campBurstCount,
   input  logic [7:0]  campBurstOpts,
   input  logic [63:0] campDataInit,
   input  logic [63:0] campDataIncr,
   output logic        campParamsStop,

   output logic        campDoneValid,
   output logic        campDoneStatusOk,
   output logic [15:0] campFailCount,
   input  logic        campDoneStop,

   smi_mem_lib_write_test_sequencer64_if.master testPort
);

   typedef enum logic [1:0] {
      CampIdle,
      CampIssue,
      CampWait,
      CampReport
   } campStateT;

   campStateT   state;
   campStateT   nextState;

   logic [15:0] failCount;
   logic [63:0] curAddr;
   logic [63:0] addrStride;
   logic [31:0] burstLen;
   logic [7:0]  burstOpts;
   logic [63:0] curDataInit;
   logic [63:0] dataIncr;
   logic [63:0] dataSpan;
   logic [15:0] remaining;

   logic        descAccept;
   logic        doneAccept;

   // Only one burst is ever in flight, so the handshakes reduce to state plus valid.
   assign descAccept = (state == CampIdle) && campParamsValid;
   assign doneAccept = (state == CampWait) && testPort.testDoneValid;

   // State register
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= CampIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode
   always_comb begin
      nextState = state;
      unique case (state)
         CampIdle: begin
            if (campParamsValid) begin
               nextState = (campBurstCount == 16'd0) ? CampReport : CampIssue;
            end
         end
         CampIssue: begin
            if (!testPort.testParamsStop) begin
               nextState = CampWait;
            end
         end
         CampWait: begin
            if (testPort.testDoneValid) begin
               nextState = (remaining == 16'd1) ? CampReport : CampIssue;
            end
         end
         CampReport: begin
            if (!campDoneStop) begin
               nextState = CampIdle;
            end
         end
         default: nextState = CampIdle;
      endcase
   end

   // Failure counter saturates so a long campaign never wraps back to "all OK".
   always_ff @(posedge clk) begin
      if (srst) begin
         failCount <= 16'd0;
      end else if (descAccept) begin
         failCount <= 16'd0;
      end else if (doneAccept && !testPort.testDoneStatusOk && (failCount != 16'hFFFF)) begin
         failCount <= failCount + 16'd1;
      end
   end

   // Datapath: tracks the descriptor while idle, then steps address and data per burst.
   always_ff @(posedge clk) begin
      if (state == CampIdle) begin
         curAddr     <= campBaseAddr;
         addrStride  <= campAddrStride;
         burstLen    <= campBurstLen;
         burstOpts   <= campBurstOpts;
         curDataInit <= campDataInit;
         dataIncr    <= campDataIncr;
         dataSpan    <= campDataIncr * {32'd0, campBurstLen};
         remaining   <= campBurstCount;
      end else if (doneAccept) begin
         curAddr     <= curAddr + addrStride;
         curDataInit <= curDataInit + dataSpan;
         remaining   <= remaining - 16'd1;
      end
   end

   // Output decode: every valid/stop comes from the registered state alone.
   always_comb begin
      campParamsStop           = 1'b1;
      campDoneValid            = 1'b0;
      testPort.testParamsValid = 1'b0;
      testPort.testDoneStop    = 1'b1;
      unique case (state)
         CampIdle:   campParamsStop           = 1'b0;
         CampIssue:  testPort.testParamsValid = 1'b1;
         CampWait:   testPort.testDoneStop    = 1'b0;
         CampReport: campDoneValid            = 1'b1;
         default: ;
      endcase
   end

   assign campDoneStatusOk            = (failCount == 16'd0);
   assign campFailCount               = failCount;
   assign testPort.testParamBurstAddr = curAddr;
   assign testPort.testParamBurstLen  = burstLen;
   assign testPort.testParamBurstOpts = burstOpts;
   assign testPort.testParamDataInit  = curDataInit;
   assign testPort.testParamDataIncr  = dataIncr;

endmodule
